// File: rtl/dffram_arb_pkg.sv
// Shared constants and types for the two-port DFFRAM arbiter.
// Word-address widths: AW_128/AW_256/AW_512 select the macro depth.
package dffram_arb_pkg;

    localparam int NPORTS = 2;
    localparam int AW_128 = 7;
    localparam int AW_256 = 8;
    localparam int AW_512 = 9;
    localparam int DW     = 32;
    localparam int BW     = 4;

    // With two requesters a single bit names a port.
    typedef logic port_idx_t;

    function automatic logic [NPORTS-1:0] port_onehot(input port_idx_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dffram_arb2_grant.sv
// Winner selection plus round-robin pointer and bus-lock registers.
// Optional build macro: DFFRAM_ARB2_FIXED_PRIO_EN (port 0 wins ties, no rr pointer).
//
//   lock state          | meaning
//   --------------------+----------------------------------------------
//   r_lock_act = 0      | both ports eligible, ties go to rr pointer
//   r_lock_act = 1      | only r_lock_own eligible until it transfers
//                       | with lock deasserted
module dffram_arb2_grant
    import dffram_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NPORTS-1:0] i_valid,
    input  logic [NPORTS-1:0] i_lock,
    output logic [NPORTS-1:0] o_grant,
    output port_idx_t         o_winner
);

    logic              r_lock_act;
    port_idx_t         r_lock_own;
    port_idx_t         w_rr_ptr;
    port_idx_t         w_winner;
    logic [NPORTS-1:0] w_elig;
    logic [NPORTS-1:0] w_grant;

`ifdef DFFRAM_ARB2_FIXED_PRIO_EN
    assign w_rr_ptr = 1'b0;
`else
    port_idx_t r_rr_ptr;

    // Priority passes to the other port after every transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (|w_grant) begin
            r_rr_ptr <= ~w_winner;
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    // Eligibility and winner; grant is forced low while reset is asserted.
    always_comb begin
        w_elig = i_valid;
        if (r_lock_act) begin
            w_elig = i_valid & port_onehot(r_lock_own);
        end
        case (w_elig)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            default: w_winner = w_rr_ptr;
        endcase
        w_grant = ((|w_elig) && i_rst_n) ? port_onehot(w_winner) : '0;
    end

    // Lock is taken by any transfer with lock set, dropped by the owner's unlocked transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_act <= 1'b0;
            r_lock_own <= 1'b0;
        end else if (|w_grant) begin
            if (i_lock[w_winner]) begin
                r_lock_act <= 1'b1;
                r_lock_own <= w_winner;
            end else if (r_lock_act && (r_lock_own == w_winner)) begin
                r_lock_act <= 1'b0;
            end
        end
    end

    assign o_grant  = w_grant;
    assign o_winner = w_winner;

endmodule

// File: rtl/dffram_arb2.sv
// Two-requester arbiter in front of a single-port DFFRAM word macro.
// One transfer per cycle; read data returns one cycle after grant.
// Optional build macro: DFFRAM_ARB2_FIXED_PRIO_EN (handled in dffram_arb2_grant).
module dffram_arb2
    import dffram_arb_pkg::*;
#(
    parameter int AW = AW_128
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NPORTS-1:0]    req_valid,
    output logic [NPORTS-1:0]    req_ready,
    input  logic [NPORTS-1:0]    req_write,
    input  logic [NPORTS-1:0]    req_lock,
    input  logic [NPORTS*AW-1:0] req_addr,
    input  logic [NPORTS*DW-1:0] req_wdata,
    input  logic [NPORTS*BW-1:0] req_be,
    output logic [NPORTS-1:0]    rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 ram_en,
    output logic [BW-1:0]        ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_di,
    input  logic [DW-1:0]        ram_do
);

    logic [NPORTS-1:0] w_grant;
    port_idx_t         w_sel;
    logic              w_write;
    logic [BW-1:0]     w_be;
    logic              r_rsp_pend;
    port_idx_t         r_rsp_own;

    dffram_arb2_grant u_grant (
        .i_clk    (HCLK),
        .i_rst_n  (HRESETn),
        .i_valid  (req_valid),
        .i_lock   (req_lock),
        .o_grant  (w_grant),
        .o_winner (w_sel)
    );

    assign req_ready = w_grant;
    assign ram_en    = |w_grant;
    assign w_write   = req_write[w_sel];
    assign w_be      = w_sel ? req_be[2*BW-1:BW] : req_be[BW-1:0];
    assign ram_addr  = w_sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    assign ram_di    = w_sel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    assign ram_we    = (ram_en && w_write) ? w_be : '0;

    // A granted read produces a response tagged with its port on the next cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rsp_pend <= 1'b0;
            r_rsp_own  <= 1'b0;
        end else begin
            r_rsp_pend <= ram_en && !w_write;
            if (ram_en) begin
                r_rsp_own <= w_sel;
            end
        end
    end

    assign rsp_valid = r_rsp_pend ? port_onehot(r_rsp_own) : '0;
    assign rsp_rdata = ram_do;

endmodule

// File: tb/tb_dffram_arb2.sv
// Self-checking bench for dffram_arb2: request queues per port, a behavioural
// RAM macro, and a reference model of grant order, lock and read data.
module tb_dffram_arb2;

    localparam int AW = 7;

    logic              HCLK;
    logic              HRESETn;
    logic [1:0]        req_valid, req_ready, req_write, req_lock;
    logic [2*AW-1:0]   req_addr;
    logic [63:0]       req_wdata;
    logic [7:0]        req_be;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_di;
    logic [31:0]       ram_do;

    dffram_arb2 #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct packed {
        logic          w;
        logic          lk;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } req_t;

    req_t        q0[$];
    req_t        q1[$];
    logic [31:0] ram_mem[128];
    logic [31:0] ref_mem[128];
    int          total = 0;
    int          bad = 0;
    int          prio = 0;
    int          lock_on = 0;
    int          lock_who = 0;
    int          pend = -1;
    logic [31:0] pend_data;

    // Behavioural DFFRAM macro: byte-masked write, registered read.
    always @(posedge HCLK) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_do <= ram_mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_t r0, r1;
        r0 = (q0.size() > 0) ? q0[0] : '0;
        r1 = (q1.size() > 0) ? q1[0] : '0;
        req_valid = {q1.size() > 0, q0.size() > 0};
        req_write = {r1.w, r0.w};
        req_lock  = {r1.lk, r0.lk};
        req_addr  = {r1.a, r0.a};
        req_wdata = {r1.d, r0.d};
        req_be    = {r1.be, r0.be};
    endtask

    task automatic push(input int p, input logic w, input logic lk,
                        input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        req_t r;
        r = '{w: w, lk: lk, a: a, d: d, be: be};
        if (p == 1) q1.push_back(r);
        else        q0.push_back(r);
        drive();
    endtask

    function automatic int model_grant();
        bit e0, e1;
        e0 = (q0.size() > 0) && (lock_on == 0 || lock_who == 0);
        e1 = (q1.size() > 0) && (lock_on == 0 || lock_who == 1);
        if (e0 && e1) return prio;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        prio = 0; lock_on = 0; lock_who = 0; pend = -1;
    endtask

    // One cycle: check outputs at the negedge, advance the model at the posedge.
    task automatic step();
        int          g;
        req_t        r;
        logic [1:0]  exp_rdy, exp_rv;
        @(negedge HCLK);
        g = model_grant();
        exp_rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        exp_rv  = (pend < 0) ? 2'b00 : ((pend == 0) ? 2'b01 : 2'b10);
        chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
        chk("ram_en", {31'd0, ram_en}, {31'd0, (g >= 0)});
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rv});
        if (pend >= 0) chk("rsp_rdata", rsp_rdata, pend_data);
        r = '0;
        if (g >= 0) begin
            r = (g == 1) ? q1[0] : q0[0];
            chk("ram_addr", {25'd0, ram_addr}, {25'd0, r.a});
            chk("ram_we", {28'd0, ram_we}, {28'd0, (r.w ? r.be : 4'b0000)});
            if (r.w) chk("ram_di", ram_di, r.d);
        end
        @(posedge HCLK);
        pend = -1;
        if (g >= 0) begin
            if (r.w) begin
                for (int b = 0; b < 4; b++)
                    if (r.be[b]) ref_mem[r.a][8*b +: 8] = r.d[8*b +: 8];
            end else begin
                pend = g;
                pend_data = ref_mem[r.a];
            end
`ifdef DFFRAM_ARB2_FIXED_PRIO_EN
            prio = 0;
`else
            prio = 1 - g;
`endif
            if (r.lk) begin
                lock_on = 1; lock_who = g;
            end else if (lock_on != 0 && lock_who == g) begin
                lock_on = 0;
            end
            if (g == 1) void'(q1.pop_front());
            else        void'(q0.pop_front());
        end
        #1;
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() + q1.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_budget", q0.size() + q1.size(), 0);
    endtask

    initial begin
        HRESETn = 1'b0;
        ram_do  = '0;
        for (int i = 0; i < 128; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end
        model_reset();

        // Reset with both ports requesting: nothing may be granted.
        push(0, 1'b0, 1'b0, 7'd1, 32'd0, 4'h0);
        push(1, 1'b0, 1'b0, 7'd2, 32'd0, 4'h0);
        #12;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        drain(10);

        // Single port write then read of the same word.
        push(1, 1'b1, 1'b0, 7'd5, 32'hDEADBEEF, 4'hF);
        push(1, 1'b0, 1'b0, 7'd5, 32'd0, 4'h0);
        drain(10);
        step();

        // Byte-enable merge.
        push(0, 1'b1, 1'b0, 7'd9, 32'h11223344, 4'hF);
        push(0, 1'b1, 1'b0, 7'd9, 32'hAABBCCDD, 4'b0101);
        push(0, 1'b0, 1'b0, 7'd9, 32'd0, 4'h0);
        drain(10);
        step();
        chk("be_merge_ref", ram_mem[9], 32'h11BB33DD);

        // Contention: four reads from each port queued together.
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, 1'b0, 7'(16 + i), 32'd0, 4'h0);
            push(1, 1'b0, 1'b0, 7'(32 + i), 32'd0, 4'h0);
        end
        drain(20);
        step();

        // Lock: port 1 holds the bus for three locked transfers, then releases.
        push(1, 1'b1, 1'b1, 7'd40, 32'hCAFE0001, 4'hF);
        push(1, 1'b0, 1'b1, 7'd40, 32'd0, 4'h0);
        push(1, 1'b1, 1'b1, 7'd41, 32'hCAFE0002, 4'hF);
        push(1, 1'b0, 1'b0, 7'd41, 32'd0, 4'h0);
        step();
        push(0, 1'b0, 1'b0, 7'd40, 32'd0, 4'h0);
        drain(20);
        step();

        // Reset in the cycle after a read grant: response must vanish.
        push(0, 1'b0, 1'b0, 7'd5, 32'd0, 4'h0);
        push(1, 1'b0, 1'b1, 7'd9, 32'd0, 4'h0);
        step();
        HRESETn = 1'b0;
        model_reset();
        #1;
        chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("midrst_ready", {30'd0, req_ready}, 32'd0);
        chk("midrst_ram_en", {31'd0, ram_en}, 32'd0);
        @(negedge HCLK);
        chk("midrst_ram_en2", {31'd0, ram_en}, 32'd0);
        chk("midrst_rsp_valid2", {30'd0, rsp_valid}, 32'd0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        drain(10);
        step();

        // Randomized mixed traffic with occasional locks and idle gaps.
        for (int c = 0; c < 400; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) != 0)
                push(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                     7'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            if (q1.size() == 0 && $urandom_range(0, 2) != 0)
                push(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                     7'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            step();
        end
        drain(50);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dffram_arb2.md
# dffram_arb2

Two-requester arbiter that shares one DFFRAM word macro (128/256/512 × 32) between two native valid/ready requesters. It sits between the requesters and the macro's single port (EN0/WE0/A0/Di0/Do0), grants one transfer per cycle and returns read data one cycle after grant. Round-robin fairness and a bus-lock for atomic sequences are provided.

## Interface
- AW, 7, word address width (7 = 128 words, 8 = 256, 9 = 512)
- HCLK  in  1  clock; RAM macro CLK is driven from the same net
- HRESETn  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-port request valid (bit i = port i)
- req_ready  out  2  per-port grant; transfer when valid & ready
- req_write  in  2  1 = write, 0 = read
- req_lock  in  2  hold grant after this transfer
- req_addr  in  2×AW  word address
- req_wdata  in  2×32  write data
- req_be  in  2×4  byte enables (writes only)
- rsp_valid  out  2  read data valid for port i
- rsp_rdata  out  32  read data, shared, qualified by rsp_valid
- ram_en  out  1  macro EN0
- ram_we  out  4  macro WE0
- ram_addr  out  AW  macro A0
- ram_di  out  32  macro Di0
- ram_do  in  32  macro Do0

## Operation
- State: rr_ptr (port holding priority), lock_act, lock_own, rsp_pend, rsp_own.
- Grant (combinational): if lock_act, only lock_own is eligible; else if both valid, grant rr_ptr; else grant the sole valid port; none valid → no grant.
- At most one req_ready bit is high. Requester holds valid and payload stable until ready.
- Granted transfer: ram_en=1, ram_addr/ram_di from winner, ram_we = req_be if write, else 4'b0. No grant: ram_en=0, ram_we=0.
- On a transfer by port i: rr_ptr ← ~i. If req_lock[i]=1: lock_act←1, lock_own←i. If req_lock[i]=0 and lock_act with lock_own=i: lock_act←0.
- Read transfer: rsp_pend←1, rsp_own←i next edge; rsp_valid[rsp_own]=rsp_pend, rsp_rdata=ram_do. Writes produce no response.
- Back-to-back reads are fully pipelined; a read the cycle after a write to the same address returns the new data (macro behaviour).
- Lock held while owner is idle blocks the other port indefinitely; this is by design.

## Timing
- Reset values: rr_ptr=0, lock_act=0, lock_own=0, rsp_pend=0; hence rsp_valid=0, req_ready=0, ram_en=0, ram_we=0. ram_addr/ram_di/rsp_rdata don't-care.
- While HRESETn low, req_ready and ram_en are forced 0 asynchronously.
- Read latency: grant in cycle N → rsp_valid in cycle N+1. Write completes at the edge ending cycle N.
- Throughput: one transfer per cycle, any port mix.
- Reset asserted mid-operation: pending response discarded (rsp_valid drops immediately), lock released; nothing written after reset asserts.
- Simultaneous valid with no lock: alternate strictly (0,1,0,1…) starting at port 0 after reset.

## Configuration
- DFFRAM_ARB2_FIXED_PRIO_EN: defined → port 0 always wins when both valid; rr_ptr unused (tied 0). Lock still honoured.
- Undefined → round-robin as above.

## Structure
- Package dffram_arb_pkg: NPORTS=2, AW constants AW_128=7, AW_256=8, AW_512=9, DW=32, BW=4, port-index typedef.
- Sub-module dffram_arb2_grant: combinational winner select plus rr_ptr/lock registers; top level holds the datapath mux and response pipeline.

## Test plan
- Reset: HRESETn low with both valid → req_ready=0, ram_en=0, rsp_valid=0; release → port 0 granted first.
- Single port: port 1 writes 0xDEADBEEF, be=4'hF, addr 5; then reads addr 5 → rsp_valid[1] one cycle after grant, rdata=0xDEADBEEF.
- Byte enables: write 0x11223344 (be=F) then 0xAABBCCDD (be=4'b0101) → read 0x11BB33DD.
- Contention: both ports issue 4 reads continuously → grants 0,1,0,1; each rsp_valid lands on the correct port with correct data (fixed-prio build: four port-0 grants first).
- Lock: port 1 transfers with lock=1 three times while port 0 valid → port 0 blocked until port 1 transfers with lock=0, then port 0 granted next cycle.
- Reset mid-read: assert HRESETn in the cycle after a read grant → rsp_valid 0 immediately, no response after release.
